// File: rtl/ram_io_responder.sv
// Byte-serial RAM/IO responder behind the memory controller's RAM port.
// Holds the on-chip byte RAM, the character TX FIFO and the sticky halt/overflow flags.
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_AW        = 4
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        rdy_in,
  input  logic        r_or_w,
  input  logic [31:0] a_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        io_full,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  output logic        halt,
  output logic        io_overflow
);

  localparam logic [FIFO_AW:0]   CNT_MAX  = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_NEAR = (FIFO_AW+1)'(FIFO_DEPTH - 2);
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  logic [7:0] mem      [0:(1 << RAM_ADDR_WIDTH) - 1];
  logic [7:0] fifo_buf [0:FIFO_DEPTH - 1];

  logic [7:0]         d_out_q, d_out_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               halt_q, halt_d;
  logic               ovf_q, ovf_d;

  logic                      io_sel, wr_en, rd_en, tx_wr, halt_wr, ram_wr;
  logic                      pop, push, fifo_full, ovf_set;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      unused_addr_hi;

  assign unused_addr_hi = ^a_in[31:18];

  assign io_sel   = (a_in[17:16] == 2'b11);
  assign ram_addr = a_in[RAM_ADDR_WIDTH-1:0];
  assign wr_en    = rdy_in && r_or_w;
  assign rd_en    = rdy_in && !r_or_w;
  assign tx_wr    = wr_en && (a_in[17:0] == 18'h30000);
  assign halt_wr  = wr_en && (a_in[17:0] == 18'h30004);
  assign ram_wr   = wr_en && !io_sel;

  // Drain runs regardless of rdy_in; a pop on a full FIFO makes room for a same-cycle push.
  assign pop       = (count_q != '0) && io_tx_ready;
  assign fifo_full = (count_q == CNT_MAX);
  assign push      = tx_wr && (!fifo_full || pop);
  assign ovf_set   = tx_wr && fifo_full && !pop;

  always_comb begin
    d_out_d  = d_out_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q | halt_wr;
    ovf_d    = ovf_q | ovf_set;
    if (rd_en) begin
      d_out_d = io_sel ? 8'h00 : mem[ram_addr];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      d_out_q  <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      d_out_q  <= d_out_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset so they map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (ram_wr) begin
      mem[ram_addr] <= d_in;
    end
    if (push) begin
      fifo_buf[wr_ptr_q] <= d_in;
    end
  end

  assign d_out       = d_out_q;
  assign io_full     = (count_q >= CNT_NEAR);
  assign io_tx_data  = fifo_buf[rd_ptr_q];
  assign io_tx_valid = (count_q != '0);
  assign halt        = halt_q;
  assign io_overflow = ovf_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: read-data and TX-byte scoreboards against a small
// behavioural model of the RAM, the TX FIFO and the sticky flags.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b0;
  logic        rdy_in = 1'b0;
  logic        r_or_w = 1'b0;
  logic [31:0] a_in = 32'h0003_0008;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic        io_full;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready = 1'b0;
  logic        halt;
  logic        io_overflow;

  int total = 0;
  int bad = 0;

  logic [7:0] mmem [int];
  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];
  int         mcount = 0;
  logic       m_ov = 1'b0;
  logic       m_halt = 1'b0;
  logic [7:0] last_d = 8'h00;

  ram_io_responder dut (
    .clk_in      (clk_in),
    .rst_in_n    (rst_in_n),
    .rdy_in      (rdy_in),
    .r_or_w      (r_or_w),
    .a_in        (a_in),
    .d_in        (d_in),
    .d_out       (d_out),
    .io_full     (io_full),
    .io_tx_data  (io_tx_data),
    .io_tx_valid (io_tx_valid),
    .io_tx_ready (io_tx_ready),
    .halt        (halt),
    .io_overflow (io_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check flags against the model before the edge, advance the model, then check d_out.
  task automatic tick();
    logic pop, push_req, rd, is_io;
    int   mc0;
    chk("tx_valid", io_tx_valid, mcount != 0);
    chk("io_full", io_full, mcount >= 14);
    chk("overflow", io_overflow, m_ov);
    chk("halt", halt, m_halt);
    chk("count", 32'(dut.count_q), mcount);
    mc0 = mcount;
    pop = (mcount != 0) && io_tx_ready;
    if (pop) begin
      chk("tx_data", io_tx_data, tx_q[0]);
      void'(tx_q.pop_front());
      mcount--;
    end
    is_io = (a_in[17:16] == 2'b11);
    push_req = rdy_in && r_or_w && (a_in[17:0] == 18'h30000);
    if (push_req) begin
      if (mc0 < 16 || pop) begin
        tx_q.push_back(d_in);
        mcount++;
      end else begin
        m_ov = 1'b1;
      end
    end
    if (rdy_in && r_or_w && (a_in[17:0] == 18'h30004)) m_halt = 1'b1;
    if (rdy_in && r_or_w && !is_io) mmem[int'(a_in & 32'h1FFFF)] = d_in;
    rd = rdy_in && !r_or_w;
    if (rd) rd_q.push_back(is_io ? 8'h00 : mmem[int'(a_in & 32'h1FFFF)]);
    @(posedge clk_in);
    #1;
    if (rd) last_d = rd_q.pop_front();
    chk("d_out", d_out, last_d);
  endtask

  task automatic drv(input logic rdy, input logic rw, input logic [31:0] a, input logic [7:0] d);
    rdy_in = rdy;
    r_or_w = rw;
    a_in   = a;
    d_in   = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b1, 1'b0, 32'h0003_0008, 8'h00);
  endtask

  task automatic do_reset();
    rst_in_n = 1'b0;
    rdy_in = 1'b0;
    #1;
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_io_full", io_full, 1'b0);
    chk("rst_tx_valid", io_tx_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_overflow", io_overflow, 1'b0);
    mcount = 0;
    tx_q.delete();
    rd_q.delete();
    m_ov = 1'b0;
    m_halt = 1'b0;
    last_d = 8'h00;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in_n = 1'b1;
  endtask

  initial begin
    int sent;
    int guard;
    #2;
    do_reset();

    // Traffic in flight, then reset drops the queued TX bytes.
    io_tx_ready = 1'b0;
    drv(1'b1, 1'b1, 32'h0003_0000, 8'h31);
    drv(1'b1, 1'b1, 32'h0003_0000, 8'h32);
    drv(1'b1, 1'b1, 32'h0000_0200, 8'hEE);
    do_reset();
    idle(1);

    for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 32'h100 + i, 8'(8'h11 * (i + 1)));
    drv(1'b1, 1'b1, 32'h10, 8'h77);
    for (int i = 0; i < 4; i++) drv(1'b1, 1'b0, 32'h100 + i, 8'h00);
    idle(1);

    io_tx_ready = 1'b1;
    drv(1'b1, 1'b1, 32'h0003_0000, 8'h41);
    drv(1'b1, 1'b1, 32'h0003_0000, 8'h42);
    idle(3);
    chk("out_path_empty", io_tx_valid, 1'b0);

    io_tx_ready = 1'b0;
    for (int i = 0; i < 14; i++) drv(1'b1, 1'b1, 32'h0003_0000, 8'(8'h60 + i));
    chk("full_after_14", io_full, 1'b1);
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, 32'h0003_0000, 8'(8'h6E + i));
    chk("count_16", 32'(dut.count_q), 16);
    chk("ovf_17th", io_overflow, 1'b1);
    chk("head_first", io_tx_data, 8'h60);
    io_tx_ready = 1'b1;
    idle(18);

    do_reset();
    io_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) drv(1'b1, 1'b1, 32'h0003_0000, 8'(8'h80 + i));
    io_tx_ready = 1'b1;
    drv(1'b1, 1'b1, 32'h0003_0000, 8'hA0);
    chk("pushpop_count", 32'(dut.count_q), 16);
    chk("pushpop_no_ovf", io_overflow, 1'b0);
    idle(18);

    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 2000) begin
      io_tx_ready = 1'($urandom_range(0, 1));
      if (mcount < 14) begin
        drv(1'b1, 1'b1, 32'h0003_0000, 8'(8'hC0 + sent));
        sent++;
      end else begin
        idle(1);
      end
      guard++;
    end
    chk("wrap_sent", sent, 40);
    io_tx_ready = 1'b1;
    idle(20);
    chk("wrap_drained", io_tx_valid, 1'b0);

    drv(1'b1, 1'b1, 32'h0003_0004, 8'h99);
    drv(1'b1, 1'b1, 32'h0003_0008, 8'h5B);
    drv(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    drv(1'b1, 1'b0, 32'h0000_0100, 8'h00);
    drv(1'b1, 1'b0, 32'hFFFC_0101, 8'h00);
    drv(1'b1, 1'b0, 32'h0003_0004, 8'h00);
    idle(2);
    chk("halt_sticky", halt, 1'b1);

    drv(1'b1, 1'b0, 32'h0000_0102, 8'h00);
    drv(1'b0, 1'b1, 32'h0000_0010, 8'h5A);
    drv(1'b0, 1'b0, 32'h0000_0010, 8'h00);
    chk("rdy_hold", d_out, 8'h33);
    io_tx_ready = 1'b0;
    drv(1'b1, 1'b1, 32'h0003_0000, 8'h55);
    io_tx_ready = 1'b1;
    drv(1'b0, 1'b1, 32'h0003_0000, 8'h56);
    drv(1'b0, 1'b0, 32'h0003_0004, 8'h00);
    drv(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    chk("rdy_gated_write", d_out, 8'h77);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
